// File: rtl/counter_sequencer_pkg.sv
// counter_sequencer shared definitions
// states, counter mode codes and command layout
package counter_sequencer_pkg;

  localparam logic [1:0] MODE_UP  = 2'b00;
  localparam logic [1:0] MODE_DN  = 2'b01;
  localparam logic [1:0] MODE_DN3 = 2'b10;
  localparam logic [1:0] MODE_LD  = 2'b11;

  localparam int CMD_W = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_LD,
    S_RUN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] d;
    logic [3:0] len;
  } cmd_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/counter_sequencer_fifo.sv
// seq_cmd_fifo: DEPTH x CMD_W command buffer
// synchronous, active-high reset, head visible on pop_data
module seq_cmd_fifo
  import counter_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  output logic [CMD_W-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (do_pop && !do_push)
        count <= count - (AW+1)'(1);
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven sequencer for the mode counter
// SEQ_RCO_STOP_EN: end RUN on the first cycle that sees ctr_rco
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int LOAD_TIMEOUT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [3:0] cmd_d,
  input  logic [3:0] cmd_len,
  output logic       ctr_enable,
  output logic [1:0] ctr_mode,
  output logic [3:0] ctr_D,
  input  logic [3:0] ctr_q,
  input  logic       ctr_rco,
  input  logic       ctr_load,
  output logic       busy,
  output logic       done,
  output logic [3:0] done_q,
  output logic [3:0] rco_cnt,
  output logic       err
);

  state_e           state;
  state_e           state_nx;
  cmd_t             cur;
  logic [CMD_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [3:0]       len_cnt;
  logic [7:0]       wait_cnt;
  logic             ld_tmo;
  logic             rco_stop;
  logic [3:0]       done_q_r;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && !fifo_empty;
  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign ld_tmo    = (wait_cnt == 8'(LOAD_TIMEOUT - 1));
  assign done_q    = (state == S_DONE) ? ctr_q : done_q_r;

`ifdef SEQ_RCO_STOP_EN
  assign rco_stop = ctr_rco;
`else
  assign rco_stop = 1'b0;
`endif

  seq_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data({cmd_mode, cmd_d, cmd_len}),
    .pop      (pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // next state and counter drive, decoded from registered state
  always_comb begin
    state_nx   = state;
    ctr_enable = 1'b0;
    ctr_mode   = 2'b00;
    ctr_D      = 4'h0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty)
          state_nx = S_LOAD;
      end
      S_LOAD: begin
        ctr_enable = 1'b1;
        ctr_mode   = MODE_LD;
        ctr_D      = cur.d;
        state_nx   = S_WAIT_LD;
      end
      S_WAIT_LD: begin
        if (ctr_load)
          state_nx = (cur.mode == MODE_LD) ? S_DONE : S_RUN;
        else if (ld_tmo)
          state_nx = S_DONE;
      end
      S_RUN: begin
        ctr_enable = 1'b1;
        ctr_mode   = cur.mode;
        if (len_cnt == 4'h0 || rco_stop)
          state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // command capture, run/wait counters and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= '0;
      len_cnt  <= 4'h0;
      wait_cnt <= 8'h0;
      rco_cnt  <= 4'h0;
      err      <= 1'b0;
      done_q_r <= 4'h0;
    end else begin
      if (pop)
        cur <= cmd_t'(head);
      if (state == S_LOAD) begin
        rco_cnt  <= 4'h0;
        err      <= 1'b0;
        wait_cnt <= 8'h0;
        len_cnt  <= cur.len;
      end
      if (state == S_WAIT_LD) begin
        wait_cnt <= wait_cnt + 8'h1;
        if (!ctr_load && ld_tmo)
          err <= 1'b1;
      end
      if (state == S_RUN) begin
        len_cnt <= len_cnt - 4'h1;
        if (ctr_rco)
          rco_cnt <= sat_inc(rco_cnt);
      end
      if (state == S_DONE)
        done_q_r <= ctr_q;
    end
  end

endmodule
